bus_cycle_seq: RTL and testbench

Parametrised machine-cycle sequencer for the 8085-compatible core, replacing the fixed T-state controller. The core issues one machine-cycle request at a time through a req/ack handshake. The block then runs the T-state sequence and drives ALE, the status pins, the strobe pins and the bus output enables. Beyond the fixed controller it adds:
- configurable forced wait states
- a READY wait timeout
- back-to-back cycle issue
- explicit HOLD/HLDA
- interrupt wake from halt

---
 rtl/bus_cycle_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_bus_cycle_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_seq.sv
// bus_cycle_seq: machine-cycle T-state sequencer for the 8085-compatible core.
// Runs one machine cycle per accepted request, with forced and READY wait
// states, an optional READY timeout, HOLD/HLDA and halt with interrupt wake.
//
// Request handshake: the core holds cyc_req with cyc_type/cyc_long stable;
// the request is accepted on the rising edge that enters T1 (from TI or from
// the last T-state of the previous cycle, when hold is not being taken), and
// cyc_ack is high for exactly that T1 clock. The core may drop or change the
// request once it has seen cyc_ack.
module bus_cycle_seq #(
    parameter int WAIT_W     = 4,
    parameter int AUTO_WAIT  = 0,
    parameter int WAIT_LIMIT = 0,
    parameter bit HOLD_ENB   = 1'b1
) (
    input  logic       clk_,
    input  logic       rst_,
    input  logic       cyc_req,
    input  logic [2:0] cyc_type,
    input  logic       cyc_long,
    output logic       cyc_ack,
    output logic       cyc_done,
    output logic       cyc_tout,
    input  logic       ready,
    input  logic       hold,
    input  logic       intr_wake,
    output logic       hlda,
    output logic       ale,
    output logic       rd_,
    output logic       wr_,
    output logic       inta_,
    output logic       iom_,
    output logic       s1,
    output logic       s0,
    output logic       oe_addl,
    output logic       oe_addh,
    output logic       oe_data,
    output logic       oe_ctl,
    output logic [3:0] tstate
);

    typedef enum logic [3:0] {
        S_TR = 4'd0,
        S_TI = 4'd1,
        S_T1 = 4'd2,
        S_T2 = 4'd3,
        S_T3 = 4'd4,
        S_T4 = 4'd5,
        S_T5 = 4'd6,
        S_T6 = 4'd7,
        S_TW = 4'd8,
        S_TH = 4'd9,
        S_TT = 4'd10
    } state_t;

    localparam logic [2:0] TY_OF  = 3'd0;
    localparam logic [2:0] TY_MR  = 3'd1;
    localparam logic [2:0] TY_MW  = 3'd2;
    localparam logic [2:0] TY_IOR = 3'd3;
    localparam logic [2:0] TY_IOW = 3'd4;
    localparam logic [2:0] TY_INA = 3'd5;
    localparam logic [2:0] TY_BI  = 3'd6;
    localparam logic [2:0] TY_HLT = 3'd7;

    localparam logic [WAIT_W-1:0] AUTO_W  = AUTO_WAIT[WAIT_W-1:0];
    localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_LIMIT[WAIT_W-1:0];
    localparam logic [WAIT_W-1:0] ONE_W   = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] MAX_W   = {WAIT_W{1'b1}};

    state_t            state_q;
    logic [2:0]        type_q;
    logic              long_q;
    logic              halt_q;
    logic              tout_q;
    logic [WAIT_W-1:0] fcnt_q;   // forced wait states still to run
    logic [WAIT_W-1:0] rcnt_q;   // READY-driven wait states entered so far

    logic   hold_take;
    logic   eff_ready;
    logic   last_t;
    logic   accept;
    state_t end_next;

    // Transition qualifiers shared by the sequencer below.
    always_comb begin
        hold_take = HOLD_ENB && hold;
        // A bus-idle cycle never waits for READY.
        eff_ready = ready || (type_q == TY_BI);
        last_t    = ((state_q == S_T3) && (type_q != TY_OF)) ||
                    ((state_q == S_T4) && (type_q == TY_OF) && !long_q) ||
                    (state_q == S_T6);
        accept    = cyc_req && !hold_take && ((state_q == S_TI) || last_t);
        if (hold_take)    end_next = S_TH;
        else if (cyc_req) end_next = S_T1;
        else              end_next = S_TI;
    end

    // T-state sequencer, request latch, wait counters, halt and timeout flags.
    always_ff @(posedge clk_ or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_TR;
            type_q  <= TY_HLT;   // decodes to status 000
            long_q  <= 1'b0;
            halt_q  <= 1'b0;
            tout_q  <= 1'b0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            case (state_q)
                S_TR: state_q <= S_TI;
                S_TI: begin
                    if (hold_take)    state_q <= S_TH;
                    else if (cyc_req) state_q <= S_T1;
                end
                S_T1: begin
                    if (type_q == TY_HLT) begin
                        state_q <= S_TT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= S_T2;
                    end
                end
                S_T2: begin
                    if (AUTO_WAIT != 0) begin
                        state_q <= S_TW;
                        fcnt_q  <= AUTO_W;
                        rcnt_q  <= '0;
                    end else if (eff_ready) begin
                        state_q <= S_T3;
                    end else begin
                        state_q <= S_TW;
                        fcnt_q  <= '0;
                        rcnt_q  <= ONE_W;
                    end
                end
                S_TW: begin
                    if (fcnt_q != '0) begin
                        // Forced waits ignore READY; the last one hands over
                        // to READY sampling.
                        fcnt_q <= fcnt_q - ONE_W;
                        if (fcnt_q == ONE_W) begin
                            if (eff_ready) state_q <= S_T3;
                            else           rcnt_q  <= ONE_W;
                        end
                    end else if (eff_ready) begin
                        state_q <= S_T3;
                    end else if ((WAIT_LIMIT != 0) && (rcnt_q == LIMIT_W)) begin
                        state_q <= S_T3;
                        tout_q  <= 1'b1;
                    end else if (rcnt_q != MAX_W) begin
                        rcnt_q <= rcnt_q + ONE_W;
                    end
                end
                S_T3: begin
                    if (type_q == TY_OF) state_q <= S_T4;
                    else                 state_q <= end_next;
                end
                S_T4: begin
                    if (long_q) state_q <= S_T5;
                    else        state_q <= end_next;
                end
                S_T5: state_q <= S_T6;
                S_T6: state_q <= end_next;
                S_TT: begin
                    if (hold_take) begin
                        state_q <= S_TH;
                    end else if (intr_wake) begin
                        state_q <= S_TI;
                        halt_q  <= 1'b0;
                    end
                end
                S_TH: begin
                    if (!hold_take) state_q <= halt_q ? S_TT : S_TI;
                end
                default: state_q <= S_TI;
            endcase

            if (accept) begin
                type_q <= cyc_type;
                long_q <= cyc_long;
                tout_q <= 1'b0;
            end
        end
    end

    // Moore decode of the bus pins from the current state and latched cycle.
    always_comb begin
        ale      = 1'b0;
        rd_      = 1'b1;
        wr_      = 1'b1;
        inta_    = 1'b1;
        oe_addl  = 1'b0;
        oe_addh  = 1'b0;
        oe_data  = 1'b0;
        oe_ctl   = 1'b1;
        hlda     = 1'b0;
        cyc_ack  = 1'b0;
        cyc_done = last_t;
        cyc_tout = tout_q;
        tstate   = state_q;

        case (type_q)
            TY_OF:   {iom_, s1, s0} = 3'b011;
            TY_MR:   {iom_, s1, s0} = 3'b010;
            TY_MW:   {iom_, s1, s0} = 3'b001;
            TY_IOR:  {iom_, s1, s0} = 3'b110;
            TY_IOW:  {iom_, s1, s0} = 3'b101;
            TY_INA:  {iom_, s1, s0} = 3'b111;
            TY_BI:   {iom_, s1, s0} = 3'b010;
            default: {iom_, s1, s0} = 3'b000;
        endcase

        case (state_q)
            S_TR: oe_ctl = 1'b0;
            S_T1: begin
                cyc_ack  = 1'b1;
                ale      = (type_q != TY_BI) && (type_q != TY_HLT);
                oe_addl  = 1'b1;
                oe_addh  = 1'b1;
                cyc_done = (type_q == TY_HLT);
            end
            S_T2, S_TW, S_T3: begin
                rd_     = !((type_q == TY_OF) || (type_q == TY_MR) || (type_q == TY_IOR));
                wr_     = !((type_q == TY_MW) || (type_q == TY_IOW));
                inta_   = (type_q != TY_INA);
                oe_addh = 1'b1;
                oe_data = (type_q == TY_MW) || (type_q == TY_IOW);
            end
            S_T4, S_T5, S_T6: oe_addh = 1'b1;
            S_TT: oe_ctl = 1'b0;
            S_TH: begin
                oe_ctl = 1'b0;
                hlda   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_seq.sv
// tb_bus_cycle_seq: scoreboard bench for bus_cycle_seq. Two instances share
// the inputs: dut_a with default parameters, dut_b with AUTO_WAIT=2 and
// WAIT_LIMIT=3 for the wait-state scenario. Each clock the expected pin
// vector is queued, then compared against the selected instance on the
// falling edge.
module tb_bus_cycle_seq;

    localparam logic [3:0] TR = 4'd0, TI = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
                           T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, TW = 4'd8, TH = 4'd9,
                           TT = 4'd10;

    logic clk_ = 1'b0;
    logic rst_ = 1'b0;
    logic cyc_req = 1'b0;
    logic [2:0] cyc_type = 3'd0;
    logic cyc_long = 1'b0;
    logic ready = 1'b1;
    logic hold = 1'b0;
    logic intr_wake = 1'b0;
    logic sel_b = 1'b0;

    logic a_ack, a_done, a_tout, a_hlda, a_ale, a_rd, a_wr, a_inta, a_iom, a_s1, a_s0;
    logic a_oal, a_oah, a_od, a_oc;
    logic [3:0] a_ts;
    logic b_ack, b_done, b_tout, b_hlda, b_ale, b_rd, b_wr, b_inta, b_iom, b_s1, b_s0;
    logic b_oal, b_oah, b_od, b_oc;
    logic [3:0] b_ts;

    logic [18:0] exp_q[$];
    logic [18:0] vec_a, vec_b, obs_vec;
    int n_checks = 0;
    int n_fail = 0;

    // clock / reset
    always #5 clk_ = ~clk_;

    bus_cycle_seq dut_a (
        .clk_(clk_), .rst_(rst_), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .cyc_long(cyc_long), .cyc_ack(a_ack), .cyc_done(a_done), .cyc_tout(a_tout),
        .ready(ready), .hold(hold), .intr_wake(intr_wake), .hlda(a_hlda),
        .ale(a_ale), .rd_(a_rd), .wr_(a_wr), .inta_(a_inta), .iom_(a_iom),
        .s1(a_s1), .s0(a_s0), .oe_addl(a_oal), .oe_addh(a_oah), .oe_data(a_od),
        .oe_ctl(a_oc), .tstate(a_ts)
    );

    bus_cycle_seq #(.WAIT_W(4), .AUTO_WAIT(2), .WAIT_LIMIT(3), .HOLD_ENB(1'b1)) dut_b (
        .clk_(clk_), .rst_(rst_), .cyc_req(cyc_req), .cyc_type(cyc_type),
        .cyc_long(cyc_long), .cyc_ack(b_ack), .cyc_done(b_done), .cyc_tout(b_tout),
        .ready(ready), .hold(hold), .intr_wake(intr_wake), .hlda(b_hlda),
        .ale(b_ale), .rd_(b_rd), .wr_(b_wr), .inta_(b_inta), .iom_(b_iom),
        .s1(b_s1), .s0(b_s0), .oe_addl(b_oal), .oe_addh(b_oah), .oe_data(b_od),
        .oe_ctl(b_oc), .tstate(b_ts)
    );

    // Vector layout: tstate, ale, rd_, wr_, inta_, iom_, s1, s0,
    //                oe_addl, oe_addh, oe_data, oe_ctl, hlda, ack, done, tout
    assign vec_a = {a_ts, a_ale, a_rd, a_wr, a_inta, a_iom, a_s1, a_s0,
                    a_oal, a_oah, a_od, a_oc, a_hlda, a_ack, a_done, a_tout};
    assign vec_b = {b_ts, b_ale, b_rd, b_wr, b_inta, b_iom, b_s1, b_s0,
                    b_oal, b_oah, b_od, b_oc, b_hlda, b_ack, b_done, b_tout};
    assign obs_vec = sel_b ? vec_b : vec_a;

    // Reference pin vector for a T-state with a given latched cycle.
    function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic [2:0] ty,
                                            input logic lng, input logic tout);
        logic ale, rd, wr, inta, oal, oah, od, oc, hl, ack, done;
        logic [2:0] stat;
        case (ty)
            3'd0: stat = 3'b011;
            3'd1: stat = 3'b010;
            3'd2: stat = 3'b001;
            3'd3: stat = 3'b110;
            3'd4: stat = 3'b101;
            3'd5: stat = 3'b111;
            3'd6: stat = 3'b010;
            default: stat = 3'b000;
        endcase
        ale = 0; rd = 1; wr = 1; inta = 1; oal = 0; oah = 0; od = 0; oc = 1;
        hl = 0; ack = 0; done = 0;
        if (st == TR || st == TT) oc = 0;
        if (st == TH) begin oc = 0; hl = 1; end
        if (st == T1) begin
            ack = 1; oal = 1; oah = 1;
            ale = !(ty == 3'd6 || ty == 3'd7);
            done = (ty == 3'd7);
        end
        if (st == T2 || st == TW || st == T3) begin
            rd = !(ty == 3'd0 || ty == 3'd1 || ty == 3'd3);
            wr = !(ty == 3'd2 || ty == 3'd4);
            inta = !(ty == 3'd5);
            oah = 1;
            od = (ty == 3'd2 || ty == 3'd4);
            done = (st == T3) && (ty != 3'd0);
        end
        if (st == T4) begin oah = 1; done = !lng; end
        if (st == T5) oah = 1;
        if (st == T6) begin oah = 1; done = 1; end
        return {st, ale, rd, wr, inta, stat, oal, oah, od, oc, hl, ack, done, tout};
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue the expected vector, then compare once the clock has produced it.
    task automatic tick(input string tag, input logic [3:0] st, input logic [2:0] ty,
                        input logic lng, input logic tout);
        exp_q.push_back(exp_vec(st, ty, lng, tout));
        @(negedge clk_);
        check(tag, obs_vec, exp_q.pop_front());
    endtask

    task automatic req(input logic [2:0] ty, input logic lng);
        cyc_req  = 1'b1;
        cyc_type = ty;
        cyc_long = lng;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // 1: reset, MR with ready=1
        tick("rst_tr", TR, 3'd7, 0, 0);
        rst_ = 1'b1;
        tick("mr_ti0", TI, 3'd7, 0, 0);
        req(3'd1, 0);
        tick("mr_t1", T1, 3'd1, 0, 0);
        cyc_req = 1'b0;
        tick("mr_t2", T2, 3'd1, 0, 0);
        tick("mr_t3", T3, 3'd1, 0, 0);
        tick("mr_ti", TI, 3'd1, 0, 0);

        // 2: long OF then back-to-back MW
        req(3'd0, 1);
        tick("of_t1", T1, 3'd0, 1, 0);
        req(3'd2, 0);
        tick("of_t2", T2, 3'd0, 1, 0);
        tick("of_t3", T3, 3'd0, 1, 0);
        tick("of_t4", T4, 3'd0, 1, 0);
        tick("of_t5", T5, 3'd0, 1, 0);
        tick("of_t6", T6, 3'd0, 1, 0);
        tick("mw_t1", T1, 3'd2, 0, 0);
        cyc_req = 1'b0;
        tick("mw_t2", T2, 3'd2, 0, 0);
        tick("mw_t3", T3, 3'd2, 0, 0);
        tick("mw_ti", TI, 3'd2, 0, 0);

        // 4: hold raised mid IOW
        req(3'd4, 0);
        tick("iow_t1", T1, 3'd4, 0, 0);
        cyc_req = 1'b0;
        tick("iow_t2", T2, 3'd4, 0, 0);
        hold = 1'b1;
        tick("iow_t3", T3, 3'd4, 0, 0);
        tick("iow_th", TH, 3'd4, 0, 0);
        tick("iow_th2", TH, 3'd4, 0, 0);
        hold = 1'b0;
        tick("iow_ti", TI, 3'd4, 0, 0);

        // 5: halt, hold during halt, wake
        req(3'd7, 0);
        tick("hlt_t1", T1, 3'd7, 0, 0);
        cyc_req = 1'b0;
        tick("hlt_tt", TT, 3'd7, 0, 0);
        hold = 1'b1;
        tick("hlt_th", TH, 3'd7, 0, 0);
        hold = 1'b0;
        tick("hlt_tt2", TT, 3'd7, 0, 0);
        hold = 1'b1;
        intr_wake = 1'b1;
        tick("hlt_th_wake", TH, 3'd7, 0, 0);
        hold = 1'b0;
        intr_wake = 1'b0;
        tick("hlt_tt3", TT, 3'd7, 0, 0);
        intr_wake = 1'b1;
        tick("hlt_wake_ti", TI, 3'd7, 0, 0);
        intr_wake = 1'b0;

        // 6: async reset during TW
        req(3'd1, 0);
        tick("rw_t1", T1, 3'd1, 0, 0);
        cyc_req = 1'b0;
        ready = 1'b0;
        tick("rw_t2", T2, 3'd1, 0, 0);
        tick("rw_tw1", TW, 3'd1, 0, 0);
        tick("rw_tw2", TW, 3'd1, 0, 0);
        #2 rst_ = 1'b0;
        exp_q.push_back(exp_vec(TR, 3'd7, 0, 0));
        #1 check("async_rst", obs_vec, exp_q.pop_front());
        tick("rst_hold", TR, 3'd7, 0, 0);
        rst_ = 1'b1;
        ready = 1'b1;
        tick("rst_ti", TI, 3'd7, 0, 0);

        // 3: forced waits plus READY timeout on dut_b
        sel_b = 1'b1;
        req(3'd1, 0);
        ready = 1'b0;
        tick("to_t1", T1, 3'd1, 0, 0);
        cyc_req = 1'b0;
        tick("to_t2", T2, 3'd1, 0, 0);
        for (int i = 0; i < 5; i++) tick($sformatf("to_tw%0d", i), TW, 3'd1, 0, 0);
        tick("to_t3", T3, 3'd1, 0, 1);
        tick("to_ti", TI, 3'd1, 0, 1);
        req(3'd0, 0);
        ready = 1'b1;
        tick("fw_t1", T1, 3'd0, 0, 0);
        cyc_req = 1'b0;
        tick("fw_t2", T2, 3'd0, 0, 0);
        tick("fw_tw0", TW, 3'd0, 0, 0);
        tick("fw_tw1", TW, 3'd0, 0, 0);
        tick("fw_t3", T3, 3'd0, 0, 0);
        tick("fw_t4", T4, 3'd0, 0, 0);
        tick("fw_ti", TI, 3'd0, 0, 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
